// File: rtl/regfile_wb_arb_pkg.sv
// Shared write-back types: the request struct that travels through the B FIFO,
// the per-cycle grant encoding and a ceiling-log2 helper for pointer sizing.
package regfile_wb_arb_pkg;

  localparam int unsigned WB_WIDTH   = 32;
  localparam int unsigned WB_REGBITS = 3;

  typedef struct packed {
    logic [WB_REGBITS-1:0] wa;
    logic [WB_WIDTH-1:0]   wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  function automatic int unsigned log2_ceil(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_wb_arb_if.sv
// Bus bundle between the pipeline (master) and the write-back arbiter (slave).
// B is valid/ready: a transfer happens on any edge where b_valid_i && b_ready_o;
// the master holds B stable while b_valid_i is high and b_ready_o is low.
interface regfile_wb_arb_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned REGBITS = 3
);
  logic                     a_valid_i;
  logic [REGBITS-1:0]       a_wa_i;
  logic [WIDTH-1:0]         a_wd_i;
  logic                     a_stall_o;
  logic                     b_valid_i;
  logic [REGBITS-1:0]       b_wa_i;
  logic [WIDTH-1:0]         b_wd_i;
  logic                     b_ready_o;
  logic                     regwrite_o;
  logic [REGBITS-1:0]       wa_o;
  logic [WIDTH-1:0]         wd_o;
  logic [(1<<REGBITS)-1:0]  pending_o;

  modport master (
    output a_valid_i, a_wa_i, a_wd_i, b_valid_i, b_wa_i, b_wd_i,
    input  a_stall_o, b_ready_o, regwrite_o, wa_o, wd_o, pending_o
  );

  modport slave (
    input  a_valid_i, a_wa_i, a_wd_i, b_valid_i, b_wa_i, b_wd_i,
    output a_stall_o, b_ready_o, regwrite_o, wa_o, wd_o, pending_o
  );
endinterface

// File: rtl/regfile_wb_arb_fifo.sv
// Synchronous FIFO of write-back requests with wrap-bit pointers; also exposes
// which slots are live and their destination registers for hazard tracking.
module wb_fifo
  import regfile_wb_arb_pkg::*;
#(
  parameter type         req_t   = wb_req_t,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned REGBITS = WB_REGBITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push_i,
  input  req_t                            req_i,
  input  logic                            pop_i,
  output req_t                            head_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [DEPTH-1:0]                ent_vld_o,
  output logic [DEPTH-1:0][REGBITS-1:0]   ent_wa_o
);

  localparam int unsigned AW = log2_ceil(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  req_t          mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: slot liveness comes only from the pointers.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= req_i;
  end

  always_comb begin
    logic [AW-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = AW'(i) - rd_ptr_q[AW-1:0];
      ent_vld_o[i] = ({1'b0, off} < count);
      ent_wa_o[i]  = mem_q[i].wa;
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Register-file write-back arbiter: merges single-cycle ALU results (A) with
// FIFO-buffered long-latency results (B) into one registered write per cycle.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned REGBITS      = 3,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic              clk,
  input logic              rst_n,
  regfile_wb_arb_if.slave  wb
);

  localparam int unsigned NREG = 1 << REGBITS;
  localparam int unsigned CW   = log2_ceil(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
  } req_t;

  req_t                          enq_req;
  req_t                          head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          enq;
  logic                          deq;
  logic [DEPTH-1:0]              ent_vld;
  logic [DEPTH-1:0][REGBITS-1:0] ent_wa;

  grant_e                        gnt;
  logic                          starving;
  logic                          a_live;
  logic [CW-1:0]                 starve_q, starve_d;
  logic                          regwrite_q, regwrite_d;
  logic [REGBITS-1:0]            wa_q, wa_d;
  logic [WIDTH-1:0]              wd_q, wd_d;
  logic [NREG-1:0]               pending;

  // Zero-address B results are handshaken but never stored.
  assign enq     = wb.b_valid_i && !fifo_full && (wb.b_wa_i != '0);
  assign enq_req = '{wa: wb.b_wa_i, wd: wb.b_wd_i};

  wb_fifo #(
    .req_t   (req_t),
    .DEPTH   (DEPTH),
    .REGBITS (REGBITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (enq),
    .req_i     (enq_req),
    .pop_i     (deq),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .ent_vld_o (ent_vld),
    .ent_wa_o  (ent_wa)
  );

  // Starvation is decided from registered state only, so the stall never
  // depends combinationally on this cycle's A request.
  assign starving = (starve_q == CW'(STARVE_LIMIT)) && !fifo_empty;
  assign a_live   = wb.a_valid_i && (wb.a_wa_i != '0);

  always_comb begin
    gnt = GNT_NONE;
    if (starving)         gnt = GNT_B;
    else if (a_live)      gnt = GNT_A;
    else if (!fifo_empty) gnt = GNT_B;
  end

  assign deq = (gnt == GNT_B);

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || deq)                 starve_d = '0;
    else if (starve_q != CW'(STARVE_LIMIT)) starve_d = starve_q + CW'(1);
  end

  always_comb begin
    regwrite_d = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    case (gnt)
      GNT_A: begin
        regwrite_d = 1'b1;
        wa_d       = wb.a_wa_i;
        wd_d       = wb.a_wd_i;
      end
      GNT_B: begin
        regwrite_d = 1'b1;
        wa_d       = head.wa;
        wd_d       = head.wd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
    end else begin
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pending[ent_wa[i]] = 1'b1;
    end
    if (regwrite_q) pending[wa_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign wb.a_stall_o  = starving;
  assign wb.b_ready_o  = !fifo_full;
  assign wb.regwrite_o = regwrite_q;
  assign wb.wa_o       = wa_q;
  assign wb.wd_o       = wd_q;
  assign wb.pending_o  = pending;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_regfile_wb_arb;

  localparam int W    = 32;
  localparam int R    = 3;
  localparam int D    = 4;
  localparam int L    = 3;
  localparam int NREG = 1 << R;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arb_if #(.WIDTH(W), .REGBITS(R)) bus ();

  regfile_wb_arb #(
    .WIDTH        (W),
    .REGBITS      (R),
    .DEPTH        (D),
    .STARVE_LIMIT (L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;

  logic [R+W-1:0] exp_q[$];   // B results waiting, oldest first
  int             m_losses;   // consecutive cycles the head has waited
  logic           m_regwrite;
  logic [R-1:0]   m_wa;
  logic [W-1:0]   m_wd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_losses   = 0;
    m_regwrite = 1'b0;
    m_wa       = '0;
    m_wd       = '0;
  endtask

  function automatic logic model_stall();
    return (exp_q.size() != 0) && (m_losses >= L);
  endfunction

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p;
    logic [R+W-1:0]  e;
    p = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      p[e[R+W-1:W]] = 1'b1;
    end
    if (m_regwrite) p[m_wa] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Applies one clock edge worth of arbitration rules to the model.
  task automatic model_step(input logic av, input logic [R-1:0] awa, input logic [W-1:0] awd,
                            input logic bv, input logic [R-1:0] bwa, input logic [W-1:0] bwd,
                            output logic a_acc, output logic b_acc);
    logic           was_empty;
    logic           was_full;
    logic           stall;
    logic           popped;
    logic [R+W-1:0] e;
    was_empty = (exp_q.size() == 0);
    was_full  = (exp_q.size() == D);
    stall     = model_stall();
    popped    = 1'b0;
    if (stall || (!(av && awa != 0) && !was_empty)) begin
      e          = exp_q.pop_front();
      m_regwrite = 1'b1;
      m_wa       = e[R+W-1:W];
      m_wd       = e[W-1:0];
      popped     = 1'b1;
    end else if (av && awa != 0) begin
      m_regwrite = 1'b1;
      m_wa       = awa;
      m_wd       = awd;
    end else begin
      m_regwrite = 1'b0;
    end
    if (was_empty || popped) m_losses = 0;
    else if (m_losses < L)   m_losses = m_losses + 1;
    b_acc = bv && !was_full;
    if (b_acc && bwa != 0) exp_q.push_back({bwa, bwd});
    a_acc = av && !stall;
  endtask

  task automatic check_outputs();
    check("regwrite", 64'(bus.regwrite_o), 64'(m_regwrite));
    check("wa",       64'(bus.wa_o),       64'(m_wa));
    check("wd",       64'(bus.wd_o),       64'(m_wd));
    check("pending",  64'(bus.pending_o),  64'(model_pending()));
    check("a_stall",  64'(bus.a_stall_o),  64'(model_stall()));
    check("b_ready",  64'(bus.b_ready_o),  64'(exp_q.size() < D));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: checks, drives, steps the model, waits.
  task automatic cycle(input logic av, input logic [R-1:0] awa, input logic [W-1:0] awd,
                       input logic bv, input logic [R-1:0] bwa, input logic [W-1:0] bwd,
                       output logic a_acc, output logic b_acc);
    check_outputs();
    bus.a_valid_i = av;
    bus.a_wa_i    = awa;
    bus.a_wd_i    = awd;
    bus.b_valid_i = bv;
    bus.b_wa_i    = bwa;
    bus.b_wd_i    = bwd;
    model_step(av, awa, awd, bv, bwa, bwd, a_acc, b_acc);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic aa, ba;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, aa, ba);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_regwrite"}, 64'(bus.regwrite_o), 64'd0);
    check({pfx, "_wa"},       64'(bus.wa_o),       64'd0);
    check({pfx, "_wd"},       64'(bus.wd_o),       64'd0);
    check({pfx, "_pending"},  64'(bus.pending_o),  64'd0);
    check({pfx, "_a_stall"},  64'(bus.a_stall_o),  64'd0);
    check({pfx, "_b_ready"},  64'(bus.b_ready_o),  64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic           aa, ba;
    logic           av, bv;
    logic [R-1:0]   awa, bwa;
    logic [W-1:0]   awd, bwd;
    logic           a_held, b_held;
    int             bidx;
    logic [R+W-1:0] items[5];

    rst_n         = 1'b0;
    bus.a_valid_i = 1'b0;
    bus.a_wa_i    = '0;
    bus.a_wd_i    = '0;
    bus.b_valid_i = 1'b0;
    bus.b_wa_i    = '0;
    bus.b_wd_i    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // A only: one-cycle latency to the write port.
    cycle(1'b1, 3'd5, 32'h11, 1'b0, '0, '0, aa, ba);
    check("a_only_regwrite", 64'(bus.regwrite_o), 64'd1);
    check("a_only_wa",       64'(bus.wa_o),       64'd5);
    check("a_only_wd",       64'(bus.wd_o),       64'h11);
    check("a_only_pending",  64'(bus.pending_o),  64'h20);
    idle(2);

    // B only: enqueue edge, then output edge.
    cycle(1'b0, '0, '0, 1'b1, 3'd3, 32'hAB, aa, ba);
    check("b_only_queued_regwrite", 64'(bus.regwrite_o), 64'd0);
    check("b_only_queued_pending",  64'(bus.pending_o),  64'h08);
    idle(1);
    check("b_only_regwrite", 64'(bus.regwrite_o), 64'd1);
    check("b_only_wa",       64'(bus.wa_o),       64'd3);
    check("b_only_wd",       64'(bus.wd_o),       64'hAB);
    check("b_only_pending",  64'(bus.pending_o),  64'h08);
    idle(1);
    check("b_only_after_pending", 64'(bus.pending_o), 64'h00);
    idle(1);

    // Address zero on both sources: consumed, never written or tracked.
    cycle(1'b1, 3'd0, 32'hDEAD, 1'b1, 3'd0, 32'hBEEF, aa, ba);
    check("zero_b_accepted", 64'(ba), 64'd1);
    check("zero_regwrite",   64'(bus.regwrite_o), 64'd0);
    check("zero_pending",    64'(bus.pending_o),  64'd0);
    idle(2);

    // Fill and drain: A hogs the port, B only wins through starvation.
    for (int i = 0; i < 5; i++) items[i] = {R'(i + 2), W'(32'hB0 + i)};
    bidx = 0;
    for (int c = 0; c < 30; c++) begin
      if (bidx < 5) cycle(1'b1, 3'd1, W'(c), 1'b1, items[bidx][R+W-1:W], items[bidx][W-1:0], aa, ba);
      else          cycle(1'b1, 3'd1, W'(c), 1'b0, '0, '0, aa, ba);
      if (bidx < 5 && ba) bidx++;
    end
    check("fill_all_accepted", 64'(bidx), 64'd5);
    idle(8);

    // Reset mid-operation with three entries queued and a write in flight.
    cycle(1'b1, 3'd1, 32'h1, 1'b1, 3'd2, 32'hC2, aa, ba);
    cycle(1'b1, 3'd1, 32'h2, 1'b1, 3'd3, 32'hC3, aa, ba);
    cycle(1'b1, 3'd1, 32'h3, 1'b1, 3'd4, 32'hC4, aa, ba);
    check_outputs();
    check("midreset_pre_pending", 64'(bus.pending_o), 64'h1E);
    #2;
    rst_n = 1'b0;
    bus.a_valid_i = 1'b0;
    bus.b_valid_i = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle(6);

    // Randomized traffic; upstream retries a stalled A and holds an unaccepted B.
    a_held = 1'b0;
    b_held = 1'b0;
    av = 1'b0; awa = '0; awd = '0;
    bv = 1'b0; bwa = '0; bwd = '0;
    for (int c = 0; c < 500; c++) begin
      if (!a_held) begin
        av  = (c < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        awa = R'($urandom_range(0, NREG - 1));
        awd = $urandom;
      end
      if (!b_held) begin
        bv  = ($urandom_range(0, 1) == 1);
        bwa = R'($urandom_range(0, NREG - 1));
        bwd = $urandom;
      end
      cycle(av, awa, awd, bv, bwa, bwd, aa, ba);
      a_held = av && !aa;
      b_held = bv && !ba;
    end
    idle(12);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-back arbiter that drives the single write port of the register file. It merges two result sources:
- **A**: single-cycle ALU results, no backpressure, normal priority.
- **B**: long-latency results (load/multiply) on a valid/ready handshake, buffered in a small FIFO.

It emits at most one registered write per cycle, holds a pending-write mask for the issue stage's hazard check, and stalls source A when B has waited too long.

## Interface
- `WIDTH`, 32, data width; matches the register file.
- `REGBITS`, 3, register address width; the file holds `1<<REGBITS` registers.
- `DEPTH`, 4, B FIFO entries; power of two, ≥ 2.
- `STARVE_LIMIT`, 3, number of consecutive cycles a non-empty FIFO head may lose arbitration before A is stalled; ≥ 1.

Ports:
- `clk` in 1 — the single clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `a_valid_i` in 1 — ALU result present this cycle.
- `a_wa_i` in REGBITS — ALU destination register.
- `a_wd_i` in WIDTH — ALU result data.
- `a_stall_o` out 1 — A not consumed this cycle; upstream holds A and retries.
- `b_valid_i` in 1 — long-latency result offered.
- `b_wa_i` in REGBITS — long-latency destination register.
- `b_wd_i` in WIDTH — long-latency result data.
- `b_ready_o` out 1 — FIFO can accept a B result.
- `regwrite_o` out 1 — drives the register file write enable.
- `wa_o` out REGBITS — drives the register file write address.
- `wd_o` out WIDTH — drives the register file write data.
- `pending_o` out 1<<REGBITS — bit r set while a write to register r is still in flight.

## Operation
- **B accept:** a B transfer occurs when `b_valid_i && b_ready_o`.
  - `b_wa_i == 0`: the transfer is accepted and dropped, never enqueued.
  - Otherwise it is enqueued at the FIFO tail.
- **`b_ready_o`:** equals `!full`, with no combinational path from dequeue. A full FIFO does not accept B even in a cycle when it dequeues.
- **Per-cycle grant (exactly one of):**
  - Starving (`starve_cnt == STARVE_LIMIT`) and FIFO non-empty: grant the FIFO head and assert `a_stall_o`. A is not consumed.
  - Otherwise, if `a_valid_i` and `a_wa_i != 0`: grant A. The FIFO head waits.
  - Otherwise, if `a_valid_i` and `a_wa_i == 0`: A is consumed and discarded. The FIFO head is granted if present.
  - Otherwise, if the FIFO is non-empty: grant the FIFO head (dequeue).
  - Otherwise: no write.
- **Starvation counter `starve_cnt`:**
  - Increments each cycle the FIFO is non-empty and the head is not dequeued.
  - Clears on any dequeue or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- **Output register:** the granted write loads `regwrite_o`/`wa_o`/`wd_o` at the next edge. With no grant, `regwrite_o` is 0 and `wa_o`/`wd_o` hold their previous values.
- **`pending_o[r]`:** combinational; set if any valid FIFO entry has `wa == r`, or if `regwrite_o && wa_o == r`. Bit 0 is always 0.
- **Ordering:** the issue stage must not issue a writer to register r while `pending_o[r]` is set. Under that rule A and B never target the same register out of order, so the block does not reorder or merge writes.

## Timing
- Reset values:
  - Outputs: `regwrite_o`=0, `wa_o`=0, `wd_o`=0, `pending_o`=0, `a_stall_o`=0, `b_ready_o`=1.
  - Internal state: FIFO empty, `starve_cnt`=0.
- **Reset mid-operation:** FIFO contents and the in-flight output write are discarded immediately. No partial write reaches the register file after `rst_n` falls.
- **Latency:**
  - A: 1 cycle, input to `regwrite_o`.
  - B into an empty FIFO with A idle: 2 cycles (enqueue edge, then output edge).
- **Combinational outputs:** `a_stall_o` depends only on registered state (`starve_cnt`, empty flag), never on `a_valid_i`. It asserts for exactly one cycle, then `starve_cnt` clears.
- **Pointers:** `log2(DEPTH)` bits plus one wrap bit. Full means the pointers are equal with wrap bits different; empty means the pointers are equal with wrap bits equal.
- **Simultaneous enqueue and dequeue:** on a non-full FIFO, occupancy is unchanged. The enqueued entry appears in `pending_o` the next cycle.

## Structure
- A shared write-back package defines:
  - a `wb_req` struct {`wa`, `wd`};
  - the log2 helper.
- One sub-module, `wb_fifo`: synchronous FIFO of `wb_req`, `DEPTH` entries, async active-low reset. It exposes the full and empty flags and a per-entry valid/address view for building `pending_o`.
- The arbitration, starvation counter and output register live in the top level.

## Test plan
- **A only:** `a_valid_i`=1, `a_wa_i`=5, `a_wd_i`=0x11 → next cycle `regwrite_o`=1, `wa_o`=5, `wd_o`=0x11; `pending_o`=0x20 for that cycle.
- **B only:** one transfer, `b_wa_i`=3, `b_wd_i`=0xAB, A idle → write to r3 = 0xAB two cycles later; `pending_o[3]` high from the cycle after enqueue until the cycle after the write.
- **Fill and drain:** A continuously valid to r1 with `STARVE_LIMIT`=3; push 5 B writes →
  - `b_ready_o` drops after 4 accepts;
  - `a_stall_o` pulses every 4th cycle;
  - each pulse writes one B entry in FIFO order.
- **Address zero:** A or B with `wa`=0 → accepted, `regwrite_o` stays 0, `pending_o[0]` stays 0.
- **Reset mid-operation:** 3 entries queued, `rst_n` pulsed low mid-cycle → outputs 0 immediately, `b_ready_o`=1, no further writes after release.
